// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full adder walks the operands LSB first,
// producing a WIDTH-bit result after WIDTH RUN cycles.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_shift;
   logic             r_carry;
   logic [CW-1:0]    r_count;

   logic             w_sum;
   logic             w_carryOut;
   logic             w_last;
   logic [WIDTH-1:0] w_shiftNext;

   assign w_sum       = r_a[0] ^ r_b[0] ^ r_carry;
   assign w_carryOut  = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
   assign w_last      = (r_count == CW'(WIDTH - 1));
   // Sum bits enter at the MSB so the first (LSB) result ends up in bit 0.
   assign w_shiftNext = WIDTH'({w_sum, r_shift} >> 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_shift <= '0;
         r_carry <= 1'b0;
         r_count <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         s       <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  r_a     <= a;
                  r_b     <= b ^ {WIDTH{sub}};
                  r_carry <= sub | cin;
                  r_count <= '0;
                  busy    <= 1'b1;
                  r_state <= RUN;
               end else begin
                  busy    <= 1'b0;
                  r_state <= IDLE;
               end
            end
            RUN: begin
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_shift <= w_shiftNext;
               r_carry <= w_carryOut;
               // On the last bit r_carry still holds the carry into the MSB.
               if (w_last) begin
                  s       <= w_shiftNext;
                  cout    <= w_carryOut;
                  ovf     <= r_carry ^ w_carryOut;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_count <= r_count + CW'(1);
               end
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit instance for arithmetic, protocol
// and reset cases, and a 1-bit instance swept over every input combination.
module tb_serial_adder;

   typedef struct packed {
      logic [7:0] s;
      logic       cout;
      logic       ovf;
   } res_t;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       start8, cin8, sub8, busy8, done8, cout8, ovf8;
   logic [7:0] a8, b8, s8;
   logic       start1, cin1, sub1, busy1, done1, cout1, ovf1;
   logic [0:0] a1, b1, s1;

   res_t       q8[$];
   res_t       q1[$];
   res_t       curExp8;
   logic [7:0] lastS8;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
      .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
      .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1)
   );

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Reference: plain integer arithmetic; overflow from operand/result signs.
   function automatic res_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                  input logic cin, input logic sub);
      logic [8:0] mask, av, bb, sum, tmp;
      res_t r;
      mask  = 9'((9'd1 << w) - 9'd1);
      av    = {1'b0, a} & mask;
      bb    = sub ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
      sum   = av + bb + (sub ? 9'd1 : {8'd0, cin});
      r.s   = sum[7:0] & mask[7:0];
      tmp   = sum >> w;
      r.cout = tmp[0];
      r.ovf  = (((av >> (w - 1)) & 9'd1) == ((bb >> (w - 1)) & 9'd1)) &&
               (((sum >> (w - 1)) & 9'd1) != ((av >> (w - 1)) & 9'd1));
      return r;
   endfunction

   always @(negedge clk) begin
      res_t e;
      if (rst_n && done8) begin
         if (q8.size() == 0) checkOutput("sb8Underflow", 64'd1, 64'd0);
         else begin
            e = q8.pop_front();
            checkOutput("s8", 64'(s8), 64'(e.s));
            checkOutput("cout8", 64'(cout8), 64'(e.cout));
            checkOutput("ovf8", 64'(ovf8), 64'(e.ovf));
         end
      end
   end

   always @(negedge clk) begin
      res_t e;
      if (rst_n && done1) begin
         if (q1.size() == 0) checkOutput("sb1Underflow", 64'd1, 64'd0);
         else begin
            e = q1.pop_front();
            checkOutput("s1", 64'(s1), 64'(e.s));
            checkOutput("cout1", 64'(cout1), 64'(e.cout));
            checkOutput("ovf1", 64'(ovf1), 64'(e.ovf));
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
      a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
      curExp8 = model(8, a, b, cin, sub);
      q8.push_back(curExp8);
   endtask

   // Walk the eight RUN cycles and the DONE cycle of the operation just accepted.
   task automatic waitResult(input bit hold, input bit glitch);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (!hold && i == 0) start8 = 1'b0;
         checkOutput("busyRun", 64'(busy8), 64'd1);
         checkOutput("doneRun", 64'(done8), 64'd0);
         checkOutput("sHeld", 64'(s8), 64'(lastS8));
         a8 = 8'($urandom); b8 = 8'($urandom);
         cin8 = 1'($urandom); sub8 = 1'($urandom);
         if (glitch && i == 3) start8 = 1'b1;
         if (glitch && i == 4) start8 = 1'b0;
      end
      @(negedge clk);
      checkOutput("doneLatency", 64'(done8), 64'd1);
      checkOutput("busyDone", 64'(busy8), 64'd0);
      lastS8 = curExp8.s;
   endtask

   task automatic runOp(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, input bit glitch);
      applyStimulus(a, b, cin, sub);
      waitResult(1'b0, glitch);
      @(negedge clk);
      checkOutput("donePulse", 64'(done8), 64'd0);
      checkOutput("idleBusy", 64'(busy8), 64'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [3:0] v;
      res_t e1;
      start8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
      start1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0;
      lastS8 = 8'h00;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rstBusy", 64'(busy8), 64'd0);
      checkOutput("rstDone", 64'(done8), 64'd0);
      checkOutput("rstS", 64'(s8), 64'd0);
      checkOutput("rstCout", 64'(cout8), 64'd0);
      checkOutput("rstOvf", 64'(ovf8), 64'd0);
      checkOutput("rstDone1", 64'(done1), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("idleAfterRst", 64'(busy8), 64'd0);

      // Arithmetic corner cases (start held one cycle).
      runOp(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
      runOp(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
      runOp(8'h7F, 8'h00, 1'b1, 1'b0, 1'b0);
      runOp(8'h05, 8'h07, 1'b1, 1'b1, 1'b0);
      runOp(8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
      runOp(8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0);

      // Start pulsed mid-RUN with fresh operands must not disturb the result.
      runOp(8'h21, 8'h43, 1'b0, 1'b0, 1'b1);
      runOp(8'h90, 8'h0F, 1'b0, 1'b1, 1'b1);

      // Back-to-back: start held through DONE, one result every 9 cycles.
      applyStimulus(8'h01, 8'h02, 1'b0, 1'b0);
      waitResult(1'b1, 1'b0);
      applyStimulus(8'h10, 8'h20, 1'b1, 1'b0);
      waitResult(1'b1, 1'b0);
      applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0);
      waitResult(1'b1, 1'b0);
      applyStimulus(8'h00, 8'h01, 1'b0, 1'b1);
      waitResult(1'b1, 1'b0);
      start8 = 1'b0;
      @(negedge clk);
      checkOutput("b2bDoneLow", 64'(done8), 64'd0);
      checkOutput("b2bIdle", 64'(busy8), 64'd0);
      checkOutput("b2bSHold", 64'(s8), 64'(lastS8));

      // Reset in RUN cycle 4 aborts with no done pulse.
      applyStimulus(8'hC3, 8'h5A, 1'b0, 1'b0);
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("midRunBusy", 64'(busy8), 64'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("abortBusy", 64'(busy8), 64'd0);
      checkOutput("abortDone", 64'(done8), 64'd0);
      checkOutput("abortS", 64'(s8), 64'd0);
      checkOutput("abortCout", 64'(cout8), 64'd0);
      checkOutput("abortOvf", 64'(ovf8), 64'd0);
      q8.delete();
      lastS8 = 8'h00;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("abortNoDone", 64'(done8), 64'd0);
      end
      rst_n = 1'b1;
      runOp(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
      checkOutput("postRstS", 64'(s8), 64'h46);
      checkOutput("postRstCout", 64'(cout8), 64'd0);

      // WIDTH=1: every combination of a, b, cin, sub.
      for (int n = 0; n < 16; n++) begin
         v = 4'(n);
         a1 = v[0]; b1 = v[1]; cin1 = v[2]; sub1 = v[3]; start1 = 1'b1;
         e1 = model(1, {7'd0, v[0]}, {7'd0, v[1]}, v[2], v[3]);
         q1.push_back(e1);
         @(negedge clk);
         start1 = 1'b0;
         a1 = ~a1; b1 = ~b1; cin1 = ~cin1; sub1 = ~sub1;
         checkOutput("w1Busy", 64'(busy1), 64'd1);
         checkOutput("w1DoneRun", 64'(done1), 64'd0);
         @(negedge clk);
         checkOutput("w1Done", 64'(done1), 64'd1);
         checkOutput("w1BusyDone", 64'(busy1), 64'd0);
         @(negedge clk);
         checkOutput("w1DonePulse", 64'(done1), 64'd0);
      end

      checkOutput("q8Drained", 64'(q8.size()), 64'd0);
      checkOutput("q1Drained", 64'(q1.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
